circular_unshifter_seq: RTL



---
 rtl/circ_shift_pkg.sv | 13 +
 rtl/rotr_step.sv | 11 +
 rtl/circular_unshifter_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/circ_shift_pkg.sv
// Shared definitions for the circular shift/unshift blocks: FSM encoding and
// default word width.
package circ_shift_pkg;

    localparam int CIRC_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } circ_state_e;

endpackage

// File: rtl/rotr_step.sv
// One-bit rotate-right of a WIDTH-bit word; purely combinational.
module rotr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = {din[0], din[WIDTH-1:1]};

endmodule

// File: rtl/circular_unshifter_seq.sv
// Multicycle rotate-right engine that undoes circular_shifter_8 rotations.
// Define CIRC_UNSHIFT_FAST_EN for a single-cycle barrel-rotate datapath.
module circular_unshifter_seq
    import circ_shift_pkg::*;
#(
    parameter  int WIDTH = CIRC_W,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    circ_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] load_data;
    logic             load_done;
    logic [WIDTH-1:0] step_data;

`ifdef CIRC_UNSHIFT_FAST_EN
    // Rotate via a doubled word so shift 0 needs no special case.
    logic [2*WIDTH-1:0] dbl;
    assign dbl       = {in_data, in_data} >> in_shift;
    assign load_data = dbl[WIDTH-1:0];
    assign load_done = 1'b1;
    assign step_data = data_q;
`else
    assign load_data = in_data;
    assign load_done = (in_shift == '0);

    rotr_step #(.WIDTH(WIDTH)) u_rotr_step (
        .din  (data_q),
        .dout (step_data)
    );
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = load_data;
                    cnt_d   = in_shift;
                    state_d = load_done ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                // Only entered with cnt_q >= 1, so the decrement never wraps.
                data_d = step_data;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule
